hub75_panel_rx: RTL and testbench

//  Panel-side receiver for the RGB matrix serial interface (sclk/latch/blank/LED_Top/LED_Bottom/row_select).

---
 rtl/hub75_panel_rx.sv | 170 +++++++++++++++++
 tb/tb_hub75_panel_rx.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_panel_rx.sv
// hub75_panel_rx: panel-side receiver for the RGB matrix serial interface.
// Synchronizes the driver outputs into clk, rebuilds latched rows into a
// frame memory, exposes a registered read port and sticky protocol errors.
// Optional feature macro: LATCH_BLANK_CHECK_EN adds err_latch_lit, a sticky
// flag for a row latch taken while the display is lit.
module hub75_panel_rx #(
   parameter int COLS     = 32,
   parameter int ROW_BITS = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      sclk,
   input  logic                      latch,
   input  logic                      blank,
   input  logic [2:0]                LED_Top,
   input  logic [2:0]                LED_Bottom,
   input  logic [ROW_BITS-1:0]       row_select,
   input  logic                      err_clr,
   input  logic [ROW_BITS:0]         rd_row,
   input  logic [$clog2(COLS)-1:0]   rd_col,
   output logic [2:0]                rd_data,
   output logic                      frame_done,
   output logic [7:0]                frame_cnt,
   output logic                      disp_on,
   output logic [ROW_BITS-1:0]       disp_row,
   output logic                      err_underrun,
   output logic                      err_overrun
`ifdef LATCH_BLANK_CHECK_EN
   ,output logic                     err_latch_lit
`endif
);

   localparam int ROWS = 1 << ROW_BITS;
   localparam int CW   = $clog2(COLS + 2);

   typedef struct packed {
      logic                sclk;
      logic                latch;
      logic                blank;
      logic [2:0]          top;
      logic [2:0]          bot;
      logic [ROW_BITS-1:0] row;
   } pins_t;

   pins_t pins;
   pins_t s1;
   pins_t s2;
   logic  s3_sclk;
   logic  s3_latch;

   logic [COLS-1:0][2:0] shift_top;
   logic [COLS-1:0][2:0] shift_bot;
   logic [CW-1:0]        bit_cnt;
   logic [COLS-1:0][2:0] mem [2*ROWS];

   logic                 sclk_rise;
   logic                 latch_rise;
   logic [COLS-1:0][2:0] shift_top_nx;
   logic [COLS-1:0][2:0] shift_bot_nx;
   logic [CW-1:0]        cnt_nx;
   logic                 ovr_ev;
   logic                 unr_ev;
   logic                 last_row;

   assign pins = {sclk, latch, blank, LED_Top, LED_Bottom, row_select};

   // Two-flop synchronizer for the whole pin bundle plus a third stage for edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1       <= '0;
         s2       <= '0;
         s3_sclk  <= 1'b0;
         s3_latch <= 1'b0;
      end else begin
         s1       <= pins;
         s2       <= s1;
         s3_sclk  <= s2.sclk;
         s3_latch <= s2.latch;
      end
   end

   // Edge detection, next shift/count values and error events; a same-cycle shift is applied before the latch uses it.
   always_comb begin
      sclk_rise    = s2.sclk & ~s3_sclk;
      latch_rise   = s2.latch & ~s3_latch;
      shift_top_nx = shift_top;
      shift_bot_nx = shift_bot;
      cnt_nx       = bit_cnt;
      ovr_ev       = 1'b0;
      if (sclk_rise) begin
         shift_top_nx = {s2.top, shift_top[COLS-1:1]};
         shift_bot_nx = {s2.bot, shift_bot[COLS-1:1]};
         if (bit_cnt == CW'(COLS)) begin
            ovr_ev = 1'b1;
         end else begin
            ovr_ev = 1'b0;
         end
         if (bit_cnt != CW'(COLS + 1)) begin
            cnt_nx = bit_cnt + CW'(1);
         end else begin
            cnt_nx = bit_cnt;
         end
      end else begin
         cnt_nx = bit_cnt;
      end
      if (latch_rise && (cnt_nx > CW'(COLS))) begin
         ovr_ev = 1'b1;
      end else begin
         ovr_ev = ovr_ev;
      end
      unr_ev   = latch_rise && (cnt_nx != CW'(COLS));
      last_row = latch_rise && (s2.row == ROW_BITS'(ROWS - 1));
   end

   // Shift registers, bit counter and frame memory; a latch writes both halves at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shift_top <= '0;
         shift_bot <= '0;
         bit_cnt   <= '0;
         for (int i = 0; i < 2*ROWS; i++) begin
            mem[i] <= '0;
         end
      end else begin
         shift_top <= shift_top_nx;
         shift_bot <= shift_bot_nx;
         if (latch_rise) begin
            bit_cnt                 <= '0;
            mem[{1'b0, s2.row}]     <= shift_top_nx;
            mem[{1'b1, s2.row}]     <= shift_bot_nx;
         end else begin
            bit_cnt <= cnt_nx;
         end
      end
   end

   // Registered outputs: read port, frame pulse/counter, display mirror and sticky errors.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_data      <= 3'b000;
         frame_done   <= 1'b0;
         frame_cnt    <= 8'd0;
         disp_on      <= 1'b0;
         disp_row     <= '0;
         err_underrun <= 1'b0;
         err_overrun  <= 1'b0;
      end else begin
         rd_data      <= mem[rd_row][rd_col];
         frame_done   <= last_row;
         frame_cnt    <= last_row ? frame_cnt + 8'd1 : frame_cnt;
         // Loaded from s1 so the outputs change on the same edge as s2.
         disp_on      <= ~s1.blank;
         disp_row     <= s1.row;
         err_underrun <= unr_ev | (err_underrun & ~err_clr);
         err_overrun  <= ovr_ev | (err_overrun & ~err_clr);
      end
   end

`ifdef LATCH_BLANK_CHECK_EN
   // Sticky flag for a row latch taken while the display is lit (ghosting risk).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_latch_lit <= 1'b0;
      end else begin
         err_latch_lit <= (latch_rise & ~s2.blank) | (err_latch_lit & ~err_clr);
      end
   end
`endif

endmodule

// File: tb/tb_hub75_panel_rx.sv
// Self-checking bench for hub75_panel_rx: random row data is driven at the
// pins and compared against a model that keeps the full history of shifted bits.
module tb_hub75_panel_rx;
   localparam int COLS     = 32;
   localparam int ROW_BITS = 3;
   localparam int ROWS     = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       sclk = 1'b0;
   logic       latch = 1'b0;
   logic       blank = 1'b1;
   logic [2:0] LED_Top = 3'b000;
   logic [2:0] LED_Bottom = 3'b000;
   logic [2:0] row_select = 3'b000;
   logic       err_clr = 1'b0;
   logic [3:0] rd_row = 4'd0;
   logic [4:0] rd_col = 5'd0;
   logic [2:0] rd_data;
   logic       frame_done;
   logic [7:0] frame_cnt;
   logic       disp_on;
   logic [2:0] disp_row;
   logic       err_underrun;
   logic       err_overrun;
`ifdef LATCH_BLANK_CHECK_EN
   logic       err_latch_lit;
`endif

   int checks = 0;
   int failures = 0;
   int fd_count = 0;

   logic [2:0] exp_mem [2*ROWS][COLS];
   logic [2:0] htop [$];
   logic [2:0] hbot [$];
   int         nbits;
   logic       exp_unr;
   logic       exp_ovr;
   logic [7:0] exp_fcnt;

   hub75_panel_rx #(.COLS(COLS), .ROW_BITS(ROW_BITS)) dut (
      .clk(clk), .reset(reset), .sclk(sclk), .latch(latch), .blank(blank),
      .LED_Top(LED_Top), .LED_Bottom(LED_Bottom), .row_select(row_select),
      .err_clr(err_clr), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
      .frame_done(frame_done), .frame_cnt(frame_cnt), .disp_on(disp_on),
      .disp_row(disp_row), .err_underrun(err_underrun), .err_overrun(err_overrun)
`ifdef LATCH_BLANK_CHECK_EN
      , .err_latch_lit(err_latch_lit)
`endif
   );

   always #10 clk = ~clk;

   always @(negedge clk) begin
      if (frame_done === 1'b1) fd_count++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      htop.delete();
      hbot.delete();
      nbits    = 0;
      exp_unr  = 1'b0;
      exp_ovr  = 1'b0;
      exp_fcnt = 8'd0;
      for (int r = 0; r < 2*ROWS; r++)
         for (int c = 0; c < COLS; c++)
            exp_mem[r][c] = 3'b000;
   endtask

   // Row contents are the last COLS bits ever shifted; missing history reads as 0.
   task automatic model_latch(input int row);
      int n;
      int idx;
      n = htop.size();
      for (int c = 0; c < COLS; c++) begin
         idx = n - COLS + c;
         exp_mem[row][c]        = (idx >= 0) ? htop[idx] : 3'b000;
         exp_mem[ROWS + row][c] = (idx >= 0) ? hbot[idx] : 3'b000;
      end
      if (nbits != COLS) exp_unr = 1'b1;
      if (nbits > COLS)  exp_ovr = 1'b1;
      nbits = 0;
      if (row == ROWS - 1) exp_fcnt = exp_fcnt + 8'd1;
   endtask

   task automatic do_reset(input int hold);
      reset = 1'b0;
      sclk  = 1'b0;
      latch = 1'b0;
      tick(hold);
      reset = 1'b1;
      tick(1);
      model_reset();
   endtask

   task automatic shift_bit(input logic [2:0] t, input logic [2:0] b);
      LED_Top = t;
      LED_Bottom = b;
      sclk = 1'b0;
      tick(2);
      sclk = 1'b1;
      tick(2);
      sclk = 1'b0;
      htop.push_back(t);
      hbot.push_back(b);
      nbits++;
   endtask

   task automatic shift_random(input int n);
      for (int i = 0; i < n; i++)
         shift_bit(3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)));
   endtask

   task automatic do_latch(input int row);
      row_select = 3'(row);
      tick(2);
      latch = 1'b1;
      tick(2);
      latch = 1'b0;
      tick(3);
      model_latch(row);
   endtask

   task automatic shift_latch(input logic [2:0] t, input logic [2:0] b, input int row);
      row_select = 3'(row);
      LED_Top = t;
      LED_Bottom = b;
      sclk = 1'b0;
      tick(2);
      sclk = 1'b1;
      latch = 1'b1;
      tick(2);
      sclk = 1'b0;
      latch = 1'b0;
      tick(3);
      htop.push_back(t);
      hbot.push_back(b);
      nbits++;
      model_latch(row);
   endtask

   task automatic check_mem(input string name);
      for (int r = 0; r < 2*ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            @(negedge clk);
            rd_row = 4'(r);
            rd_col = 5'(c);
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (rd_data !== exp_mem[r][c]) begin
               failures++;
               $display("FAIL %s mem[%0d][%0d] got %b expected %b", name, r, c, rd_data, exp_mem[r][c]);
            end
         end
      end
   endtask

   task automatic check_flags(input string name);
      checks++;
      if (err_underrun !== exp_unr) begin
         failures++;
         $display("FAIL %s err_underrun got %b expected %b", name, err_underrun, exp_unr);
      end
      checks++;
      if (err_overrun !== exp_ovr) begin
         failures++;
         $display("FAIL %s err_overrun got %b expected %b", name, err_overrun, exp_ovr);
      end
      checks++;
      if (frame_cnt !== exp_fcnt) begin
         failures++;
         $display("FAIL %s frame_cnt got %0d expected %0d", name, frame_cnt, exp_fcnt);
      end
   endtask

   task automatic clear_err();
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
      tick(1);
      exp_unr = 1'b0;
      exp_ovr = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick(5);
      checks++;
      if ({rd_data, frame_done, frame_cnt, disp_on, disp_row, err_underrun, err_overrun} !== 18'd0) begin
         failures++;
         $display("FAIL reset_outputs got %b expected all 0",
                  {rd_data, frame_done, frame_cnt, disp_on, disp_row, err_underrun, err_overrun});
      end
      reset = 1'b1;
      tick(1);
      model_reset();
      check_mem("reset_mem");
      check_flags("reset_flags");
   endtask

   task automatic test_display();
      logic [2:0] r;
      r = 3'($urandom_range(7, 1));
      blank = 1'b0;
      row_select = r;
      tick(1);
      checks++;
      if (disp_on !== 1'b0) begin
         failures++;
         $display("FAIL disp_on_early got %b expected 0", disp_on);
      end
      tick(1);
      checks++;
      if (disp_on !== 1'b1 || disp_row !== r) begin
         failures++;
         $display("FAIL disp_follow got on=%b row=%0d expected on=1 row=%0d", disp_on, disp_row, r);
      end
      blank = 1'b1;
      tick(3);
   endtask

   task automatic test_single_row();
      for (int c = 0; c < COLS; c++)
         shift_bit((c == 0) ? 3'b100 : 3'b001, 3'b010);
      do_latch(5);
      check_flags("single_flags");
      check_mem("single_mem");
   endtask

   task automatic test_full_frame();
      int fd0;
      fd0 = fd_count;
      for (int r = 0; r < ROWS; r++) begin
         shift_random(COLS);
         do_latch(r);
      end
      tick(2);
      checks++;
      if (fd_count - fd0 !== 1) begin
         failures++;
         $display("FAIL frame_done_pulses got %0d expected 1", fd_count - fd0);
      end
      check_flags("frame_flags");
      check_mem("frame_mem");
   endtask

   task automatic test_underrun_overrun();
      shift_random(COLS - 1);
      do_latch(int'($urandom_range(6, 0)));
      check_flags("underrun_flags");
      shift_random(COLS + 1);
      do_latch(int'($urandom_range(6, 0)));
      check_flags("overrun_flags");
      check_mem("unr_ovr_mem");
      clear_err();
      check_flags("err_clr_flags");
   endtask

   task automatic test_simultaneous();
      int row;
      row = int'($urandom_range(7, 0));
      shift_random(COLS - 1);
      shift_latch(3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)), row);
      check_flags("simul_flags");
      shift_random(COLS);
      do_latch((row + 1) % ROWS);
      check_flags("simul_next_flags");
      check_mem("simul_mem");
   endtask

   task automatic test_reset_midrow();
      shift_random(10);
      do_reset(3);
      shift_random(COLS);
      do_latch(int'($urandom_range(6, 0)));
      check_flags("midrow_flags");
      check_mem("midrow_mem");
   endtask

`ifdef LATCH_BLANK_CHECK_EN
   task automatic test_latch_lit();
      checks++;
      if (err_latch_lit !== 1'b0) begin
         failures++;
         $display("FAIL latch_lit_idle got %b expected 0", err_latch_lit);
      end
      shift_random(COLS);
      blank = 1'b0;
      do_latch(2);
      blank = 1'b1;
      tick(2);
      checks++;
      if (err_latch_lit !== 1'b1) begin
         failures++;
         $display("FAIL latch_lit_set got %b expected 1", err_latch_lit);
      end
      clear_err();
      checks++;
      if (err_latch_lit !== 1'b0) begin
         failures++;
         $display("FAIL latch_lit_clr got %b expected 0", err_latch_lit);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_display();
      test_single_row();
      test_full_frame();
      test_underrun_overrun();
      test_simultaneous();
      test_reset_midrow();
`ifdef LATCH_BLANK_CHECK_EN
      test_latch_lit();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
